load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding CPU data-memory access at a time, with
// byte-lane steering, load sign/zero extension and alignment checking.
module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;

  logic        r_write, r_signed, r_err;
  logic [1:0]  r_size, r_off;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, ld_q;

  logic        accept, req_err;
  logic [1:0]  st_lane, ld_lane;
  logic        st_hi, ld_hi;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Lane index counts from bits 7:0; big-endian puts offset 0 in the top lane.
  assign st_lane = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];
  assign st_hi   = BIG_ENDIAN ? ~req_addr[1]   : req_addr[1];
  assign ld_lane = BIG_ENDIAN ? ~r_off         : r_off;
  assign ld_hi   = BIG_ENDIAN ? ~r_off[1]      : r_off[1];

  always_comb begin
    st_be    = '0;
    st_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = st_hi ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_wdata[15:0]}};
      end
      2'b10:   st_be = '1;
      default: st_be = '0;
    endcase
  end

  assign ld_byte = mem_rdata[{ld_lane, 3'b000} +: 8];
  assign ld_half = mem_rdata[{ld_hi, 4'b0000} +: 16];

  always_comb begin
    case (r_size)
      2'b00:   ld_ext = {{24{r_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{r_signed & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= '0;
      r_off    <= '0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ld_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        r_write  <= req_write;
        r_signed <= req_signed;
        r_err    <= req_err;
        r_size   <= req_size;
        r_off    <= req_addr[1:0];
        // Memory-side registers only move for real accesses so they hold otherwise.
        if (!req_err) begin
          addr_q  <= {req_addr[31:2], 2'b00};
          wdata_q <= st_wdata;
          be_q    <= st_be;
        end
      end
      if (state_q == WAIT) ld_q <= ld_ext;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_be    = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_err ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_read  = ~r_write;
        mem_write = r_write;
        mem_be    = be_q;
        state_d   = r_write ? RESP : WAIT;
      end
      WAIT: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_data  = (r_err || r_write) ? '0 : ld_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random traffic against a
// byte-addressed memory model, and back-to-back / mid-access reset sequences.
module tb_load_store_unit;
  localparam bit BE = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_read, mem_write;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Data memory: 64 words, read data registered one cycle after mem_read.
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx;
  logic [31:0] pl_word;
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_word;
    if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
    if (mem_write)
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) mem[mem_addr[7:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
  end

  // Reference view of the same memory as plain bytes by address.
  logic [7:0] sh [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] word);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_word = word;
    @(negedge clk);
    pl_en = 1'b0;
    for (int k = 0; k < 4; k++)
      sh[4*int'(idx) + k] = BE ? word[8*(3-k) +: 8] : word[8*k +: 8];
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] data,
                         output int nrd, output int nwr, output logic [31:0] s_addr,
                         output logic [31:0] s_wdata, output logic [3:0] s_be);
    int n;
    lat = -1; err = 1'b0; data = '0; nrd = 0; nwr = 0;
    s_addr = '0; s_wdata = '0; s_be = '0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read || mem_write) begin
        s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be;
      end
      if (rsp_valid) begin
        lat = c; err = rsp_err; data = rsp_data;
        break;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic        pl;
    logic [31:0] pre;
    int          lat;
    logic        err;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] mwd;
  } vec_t;

  vec_t vt [16];

  int          lat, nrd, nwr, n_low, n_rsp, n_big, ea, lane;
  logic        err, e, w, sg;
  logic [1:0]  sz;
  logic [31:0] data, s_addr, s_wdata, a, wd, v, tmp, exp_data, exp_mwd, hi, first_data;
  logic [3:0]  s_be, exp_be;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    //         w     sz     sg    addr   wdata        pl    preload       lat err   data          be       mwd
    vt[0]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        1'b1, 32'h11223380, 3, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0};
    vt[1]  = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        1'b1, 32'hABCD8001, 3, 1'b0, 32'h00008001, 4'b0000, 32'h0};
    vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h41, 32'h5A,       1'b0, 32'h0,        2, 1'b0, 32'h0,        4'b0100, 32'h5A5A5A5A};
    vt[3]  = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        1'b0, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    vt[4]  = '{1'b0, 2'b01, 1'b1, 32'h21, 32'h0,        1'b0, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    vt[5]  = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        1'b0, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    vt[6]  = '{1'b1, 2'b11, 1'b0, 32'h30, 32'hFFFF,     1'b0, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    vt[7]  = '{1'b0, 2'b10, 1'b1, 32'h24, 32'h0,        1'b1, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0};
    vt[8]  = '{1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        1'b1, 32'h80FF0102, 3, 1'b0, 32'h00000080, 4'b0000, 32'h0};
    vt[9]  = '{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        1'b1, 32'h80FF0102, 3, 1'b0, 32'hFFFF80FF, 4'b0000, 32'h0};
    vt[10] = '{1'b1, 2'b01, 1'b0, 32'h32, 32'h1234ABCD, 1'b0, 32'h0,        2, 1'b0, 32'h0,        4'b0011, 32'hABCDABCD};
    vt[11] = '{1'b1, 2'b10, 1'b0, 32'h34, 32'h89ABCDEF, 1'b0, 32'h0,        2, 1'b0, 32'h0,        4'b1111, 32'h89ABCDEF};
    vt[12] = '{1'b1, 2'b00, 1'b0, 32'h40, 32'h000000C3, 1'b0, 32'h0,        2, 1'b0, 32'h0,        4'b1000, 32'hC3C3C3C3};
    vt[13] = '{1'b0, 2'b01, 1'b1, 32'h40, 32'h0,        1'b0, 32'h0,        3, 1'b0, 32'hFFFFC35A, 4'b0000, 32'h0};
    vt[14] = '{1'b1, 2'b10, 1'b0, 32'h36, 32'h12345678, 1'b0, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    vt[15] = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        1'b1, 32'hABCD8001, 3, 1'b0, 32'hFFFF8001, 4'b0000, 32'h0};

    foreach (vt[i]) begin
      if (vt[i].pl) preload(vt[i].a[7:2], vt[i].pre);
      run_req(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd,
              lat, err, data, nrd, nwr, s_addr, s_wdata, s_be);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vt[i].err});
      chk($sformatf("vec%0d_data", i), data, vt[i].data);
      chk($sformatf("vec%0d_reads", i), nrd, (!vt[i].err && !vt[i].w) ? 1 : 0);
      chk($sformatf("vec%0d_writes", i), nwr, (!vt[i].err && vt[i].w) ? 1 : 0);
      if (!vt[i].err) chk($sformatf("vec%0d_mem_addr", i), s_addr, {vt[i].a[31:2], 2'b00});
      if (!vt[i].err && vt[i].w) begin
        chk($sformatf("vec%0d_mem_be", i), {28'b0, s_be}, {28'b0, vt[i].be});
        chk($sformatf("vec%0d_mem_wdata", i), s_wdata, vt[i].mwd);
      end
    end

    // Random traffic against the byte-level model.
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom());
    for (int it = 0; it < 300; it++) begin
      n_big = $urandom_range(0, 9);
      sz = (n_big < 3) ? 2'b00 : (n_big < 6) ? 2'b01 : (n_big < 9) ? 2'b10 : 2'b11;
      hi = $urandom();
      a = {hi[31:8], 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      w = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom();
      e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      n_big = 1 << sz;
      ea = int'(a[7:0]);
      exp_data = '0;
      exp_be = '0;
      exp_mwd = (n_big == 1) ? {4{wd[7:0]}} : (n_big == 2) ? {2{wd[15:0]}} : wd;
      if (!e && !w) begin
        v = '0;
        for (int k = 0; k < n_big; k++)
          v = BE ? ((v << 8) | 32'(sh[ea+k])) : (v | (32'(sh[ea+k]) << (8*k)));
        if (sg && n_big < 4 && v[8*n_big-1]) v = v | (32'hFFFFFFFF << (8*n_big));
        exp_data = v;
      end
      run_req(w, sz, sg, a, wd, lat, err, data, nrd, nwr, s_addr, s_wdata, s_be);
      if (!e && w) begin
        for (int k = 0; k < n_big; k++) begin
          tmp = BE ? (wd >> (8*(n_big-1-k))) : (wd >> (8*k));
          sh[ea+k] = tmp[7:0];
          lane = BE ? 3 - ((ea + k) % 4) : (ea + k) % 4;
          exp_be[lane] = 1'b1;
        end
      end
      chk("rnd_latency", lat, e ? 1 : (w ? 2 : 3));
      chk("rnd_err", {31'b0, err}, {31'b0, e});
      chk("rnd_data", data, exp_data);
      chk("rnd_strobes", nrd * 2 + nwr, e ? 0 : (w ? 1 : 2));
      if (!e) chk("rnd_mem_addr", s_addr, {a[31:2], 2'b00});
      if (!e && w) begin
        chk("rnd_mem_be", {28'b0, s_be}, {28'b0, exp_be});
        chk("rnd_mem_wdata", s_wdata, exp_mwd);
      end
    end

    // Back-to-back requests: the second waits out the whole load.
    preload(6'd9, 32'hCAFEF00D);
    preload(6'd8, 32'h01020304);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h24; req_wdata = '0;
    @(posedge clk);
    #1;
    n_low = 0; n_rsp = 0; first_data = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n_rsp++;
        first_data = rsp_data;
      end
      if (req_ready) break;
      n_low++;
    end
    chk("b2b_ready_low_cycles", n_low, 3);
    chk("b2b_first_rsp_count", n_rsp, 1);
    chk("b2b_first_data", first_data, 32'hCAFEF00D);
    req_addr = 32'h20;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("b2b_second_accepted", {31'b0, req_ready}, 32'd0);
    lat = -1; data = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c; data = rsp_data;
        break;
      end
    end
    chk("b2b_second_latency", lat, 3);
    chk("b2b_second_data", data, 32'h01020304);

    // Reset in WAIT abandons the load with no response.
    preload(6'd2, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h08; req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("wrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("wrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("wrst_mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("wrst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("wrst_mem_addr", mem_addr, 32'd0);
    chk("wrst_mem_wdata", mem_wdata, 32'd0);
    chk("wrst_rsp", {31'b0, rsp_err} | rsp_data, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    chk("wrst_no_response", n_rsp, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, err, data, nrd, nwr, s_addr, s_wdata, s_be);
    chk("wrst_next_latency", lat, 3);
    chk("wrst_next_data", data, 32'h55667788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
